// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone,
    StErr
  } lsu_state_e;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } lsu_size_e;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  localparam logic [3:0] BeByte = 4'b0001;
  localparam logic [3:0] BeHalf = 4'b0011;
  localparam logic [3:0] BeWord = 4'b1111;

  // Unsupported encodings fall back to a word access.
  function automatic lsu_size_e access_size(input logic [2:0] funct3);
    lsu_size_e size;
    case (funct3)
      Funct3B, Funct3Bu: size = SzByte;
      Funct3H, Funct3Hu: size = SzHalf;
      default:           size = SzWord;
    endcase
    return size;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    lsu_size_e size;
    size = access_size(funct3);
    return ((size == SzHalf) && addr_lo[0]) || ((size == SzWord) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication, byte enables and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_rep,
  output logic [3:0]  be,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  lsu_size_e   size;

  always_comb begin
    size      = access_size(funct3);
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
    wdata_rep = wdata;
    be        = BeWord;
    rdata_ext = rdata;
    case (size)
      SzByte: begin
        wdata_rep = {4{wdata[7:0]}};
        be        = BeByte << addr_lo;
        // funct3[2] selects the unsigned variants
        rdata_ext = funct3[2] ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      SzHalf: begin
        wdata_rep = {2{wdata[15:0]}};
        be        = BeHalf << {addr_lo[1], 1'b0};
        rdata_ext = funct3[2] ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      default: begin
        wdata_rep = wdata;
        be        = BeWord;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding data-memory access with timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses without a memory request.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic        Fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_MAX - 1);

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, wdata_q, rd_q;
  logic [3:0]      be_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      lo_q;

  logic            accept, capture, misalign;
  logic [2:0]      al_f3;
  logic [1:0]      al_lo;
  logic [31:0]     al_wdata, al_rdata;
  logic [3:0]      al_be;

  // The aligner sees live inputs while idle and the captured request afterwards.
  assign al_f3 = (state_q == StIdle) ? funct3 : f3_q;
  assign al_lo = (state_q == StIdle) ? Addr[1:0] : lo_q;

  lsu_align u_align (
    .funct3    (al_f3),
    .addr_lo   (al_lo),
    .wdata     (WriteData),
    .rdata     (mem_rdata),
    .wdata_rep (al_wdata),
    .be        (al_be),
    .rdata_ext (al_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    capture  = 1'b0;
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = is_misaligned(funct3, Addr[1:0]);
`else
    misalign = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (MemReq) begin
          if (misalign) begin
            state_d = StErr;
          end else begin
            accept  = 1'b1;
            cnt_d   = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_ready) begin
          capture = ~we_q;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      lo_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= {Addr[31:2], 2'b00};
        wdata_q <= al_wdata;
        be_q    <= al_be;
        we_q    <= MemWrite;
        f3_q    <= funct3;
        lo_q    <= Addr[1:0];
      end
      if (capture) begin
        rd_q <= al_rdata;
      end
    end
  end

  // Gated by rst_n so Stall is low during reset even if MemReq is held.
  assign Stall     = rst_n & (((state_q == StIdle) & MemReq) | (state_q == StReq));
  assign Done      = (state_q == StDone);
  assign Fault     = (state_q == StErr);
  assign mem_req   = (state_q == StReq);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign ReadData  = rd_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed corner cases then random traffic vs a behavioural model.
module tb_lsu_ctrl;

  localparam int unsigned WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReq, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Addr, WriteData;
  logic        Stall, Done, Fault;
  logic [31:0] ReadData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ready;

  lsu_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .Addr      (Addr),
    .WriteData (WriteData),
    .Stall     (Stall),
    .Done      (Done),
    .ReadData  (ReadData),
    .Fault     (Fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fault;
    logic        has_mem;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned stall;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned stall_cnt = 0;
  logic        skip_mon = 1'b0;
  logic [31:0] rd_model = 32'h0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model derived from access size, offset and handshake latency.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int unsigned lat,
                       output exp_t e, output logic mis);
    int unsigned size, off, reqc;
    logic [31:0] lane;
    logic        ok;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    off = (size == 1) ? (a % 4) : (size == 2) ? ((a % 4) & 2) : 0;
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((size == 2) && (a % 2 != 0)) || ((size == 4) && (a % 4 != 0));
`endif
    e.addr = a - (a % 4);
    e.be   = 4'(((1 << size) - 1) << off);
    e.we   = we;
    if (size == 1)      e.wdata = {4{wd[7:0]}};
    else if (size == 2) e.wdata = {2{wd[15:0]}};
    else                e.wdata = wd;
    lane = rd >> (8 * off);
    if (size == 1) begin
      lane = lane & 32'hFF;
      if (f3 == 3'd0 && lane[7]) lane = lane | 32'hFFFF_FF00;
    end else if (size == 2) begin
      lane = lane & 32'hFFFF;
      if (f3 == 3'd1 && lane[15]) lane = lane | 32'hFFFF_0000;
    end
    ok   = !mis && (lat >= 1) && (lat <= WAIT_MAX);
    reqc = mis ? 0 : (ok ? lat : WAIT_MAX);
    if (ok && !we) rd_model = lane;
    e.fault   = !ok;
    e.has_mem = !mis;
    e.rdata   = rd_model;
    e.stall   = 1 + reqc;
  endtask

  // lat = REQ cycle on which mem_ready rises; 0 or > WAIT_MAX means never.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int unsigned lat);
    exp_t e;
    logic mis;
    model(we, f3, a, wd, rd, lat, e, mis);
    exp_q.push_back(e);
    @(posedge clk); #1;
    MemReq = 1'b1; MemWrite = we; funct3 = f3; Addr = a; WriteData = wd; mem_rdata = rd;
    @(posedge clk); #1;
    MemReq = 1'b0; MemWrite = 1'($urandom); funct3 = 3'($urandom);
    Addr = $urandom; WriteData = $urandom;
    if (!mis) begin
      for (int k = 1; k <= int'(WAIT_MAX); k++) begin
        mem_ready = (k == int'(lat));
        @(posedge clk); #1;
        if (k == int'(lat)) break;
      end
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {Stall, Done, Fault, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadData}, '0);
  endtask

  always @(negedge clk) begin
    if (!rst_n || skip_mon) begin
      stall_cnt = 0;
    end else begin
      if (Stall) stall_cnt++;
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          check("mem_req_unexpected", 1, 0);
        end else begin
          check("mem_req_allowed", mem_req, exp_q[0].has_mem);
          check("mem_side", {mem_we, mem_be, mem_addr, mem_wdata},
                {exp_q[0].we, exp_q[0].be, exp_q[0].addr, exp_q[0].wdata});
        end
      end
      if (Done || Fault) begin
        if (exp_q.size() == 0) begin
          check("completion_unexpected", {Done, Fault}, 2'b00);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_fault", {Done, Fault}, {~e.fault, e.fault});
          check("read_data", ReadData, e.rdata);
          check("stall_cycles", stall_cnt, e.stall);
          if (Fault) check("mem_req_in_err", mem_req, 1'b0);
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; funct3 = 3'd0; Addr = '0;
    WriteData = '0; mem_rdata = '0; mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset_initial");
    #20 rst_n = 1'b1;

    // lb 0x103, ready on first REQ cycle
    do_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1);
    // sh 0x202
    do_txn(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 1);
    // lhu 0x10, ready on fourth REQ cycle
    do_txn(1'b0, 3'b101, 32'h10, 32'h0, 32'h1234_F00D, 4);
    // lw that never gets ready
    do_txn(1'b0, 3'b010, 32'h80, 32'h0, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    check("stall_after_timeout", Stall, 1'b0);
    // ready exactly on the last allowed cycle
    do_txn(1'b0, 3'b010, 32'h84, 32'h0, 32'hCAFE_F00D, WAIT_MAX);
    // misaligned lw
    do_txn(1'b0, 3'b010, 32'h06, 32'h0, 32'h7654_3210, 2);
    // unsupported funct3 behaves as a word access
    do_txn(1'b1, 3'b111, 32'h33, 32'h1357_9BDF, 32'h0, 2);

    // reset in the middle of a REQ phase
    skip_mon = 1'b1;
    @(posedge clk); #1;
    MemReq = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; Addr = 32'h40;
    @(posedge clk); #1;
    MemReq = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_req");
    exp_q.delete();
    rd_model = 32'h0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    skip_mon = 1'b0;
    do_txn(1'b0, 3'b100, 32'h41, 32'h0, 32'h0000_9A00, 2);

    for (int i = 0; i < 200; i++) begin
      int unsigned lat;
      logic [2:0]  f3;
      f3  = 3'($urandom_range(7));
      lat = ($urandom_range(3) == 0) ? $urandom_range(0, WAIT_MAX + 2) : $urandom_range(1, 3);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_txn(1'($urandom), f3, $urandom, $urandom, $urandom, lat);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
